// File: rtl/issue_queue_sched_if.sv
// Dispatch, wakeup-broadcast and issue-slot signals of the issue-queue scheduler.
// master drives dispatch/wakeup and accepts issue; slave is the scheduler.
interface issue_queue_sched_if #(
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned PAYLOAD_W = 32,
    parameter int unsigned IDX_W     = 4
);
    logic                 dispatch_valid;
    logic                 dispatch_ready;
    logic [TAG_W-1:0]     dispatch_src1_tag;
    logic                 dispatch_src1_rdy;
    logic [TAG_W-1:0]     dispatch_src2_tag;
    logic                 dispatch_src2_rdy;
    logic [TAG_W-1:0]     dispatch_dest_tag;
    logic [PAYLOAD_W-1:0] dispatch_payload;

    logic                 wakeup_valid;
    logic [TAG_W-1:0]     wakeup_tag;

    logic                 issue_valid;
    logic                 issue_ready;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic [TAG_W-1:0]     issue_dest_tag;
    logic [IDX_W-1:0]     issue_index;

    modport master (
        output dispatch_valid, dispatch_src1_tag, dispatch_src1_rdy,
               dispatch_src2_tag, dispatch_src2_rdy, dispatch_dest_tag, dispatch_payload,
               wakeup_valid, wakeup_tag, issue_ready,
        input  dispatch_ready, issue_valid, issue_payload, issue_dest_tag, issue_index
    );

    modport slave (
        input  dispatch_valid, dispatch_src1_tag, dispatch_src1_rdy,
               dispatch_src2_tag, dispatch_src2_rdy, dispatch_dest_tag, dispatch_payload,
               wakeup_valid, wakeup_tag, issue_ready,
        output dispatch_ready, issue_valid, issue_payload, issue_dest_tag, issue_index
    );
endinterface

// File: rtl/issue_queue_sched.sv
// 16-entry issue queue: tag wakeup, lowest-index select, registered valid/ready issue slot.
// dispatch_ready and count are registered from the next-state valid vector.
module issue_queue_sched #(
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned PAYLOAD_W = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned CNT_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    issue_queue_sched_if.slave    bus,
    output logic [CNT_W-1:0]      count
);
    logic [DEPTH-1:0]     valid, rdy1, rdy2;
    logic [TAG_W-1:0]     tag1    [DEPTH];
    logic [TAG_W-1:0]     tag2    [DEPTH];
    logic [TAG_W-1:0]     dest    [DEPTH];
    logic [PAYLOAD_W-1:0] payload [DEPTH];

    logic [DEPTH-1:0] req;
    logic [DEPTH-1:0] valid_nxt;
    logic [IDX_W-1:0] grant_idx, free_idx;
    logic             any_req, any_free, load, take, disp_fire;
    logic             disp_rdy1, disp_rdy2;

    function automatic logic [CNT_W-1:0] popcnt(input logic [DEPTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(DEPTH); i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    // Select / free-entry search; descending loop so the lowest index wins.
    always_comb begin
        req       = valid & rdy1 & rdy2;
        any_req   = |req;
        any_free  = ~&valid;
        grant_idx = '0;
        free_idx  = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (req[i])    grant_idx = IDX_W'(i);
            if (!valid[i]) free_idx  = IDX_W'(i);
        end
        load      = !bus.issue_valid | bus.issue_ready;
        take      = load & any_req;
        disp_fire = bus.dispatch_valid & any_free & ~flush;
        disp_rdy1 = bus.dispatch_src1_rdy |
                    (bus.wakeup_valid & (bus.wakeup_tag == bus.dispatch_src1_tag));
        disp_rdy2 = bus.dispatch_src2_rdy |
                    (bus.wakeup_valid & (bus.wakeup_tag == bus.dispatch_src2_tag));

        valid_nxt = valid;
        if (take)      valid_nxt[grant_idx] = 1'b0;
        if (disp_fire) valid_nxt[free_idx]  = 1'b1;
        if (flush)     valid_nxt            = '0;
    end

    // Entry contents; only meaningful while the valid bit is set, so no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (disp_fire && free_idx == IDX_W'(i)) begin
                rdy1[i]    <= disp_rdy1;
                rdy2[i]    <= disp_rdy2;
                tag1[i]    <= bus.dispatch_src1_tag;
                tag2[i]    <= bus.dispatch_src2_tag;
                dest[i]    <= bus.dispatch_dest_tag;
                payload[i] <= bus.dispatch_payload;
            end else if (valid[i] && bus.wakeup_valid) begin
                if (bus.wakeup_tag == tag1[i]) rdy1[i] <= 1'b1;
                if (bus.wakeup_tag == tag2[i]) rdy2[i] <= 1'b1;
            end
        end
    end

    // Valid bits, occupancy outputs and the issue slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid              <= '0;
            count              <= '0;
            bus.dispatch_ready <= 1'b1;
            bus.issue_valid    <= 1'b0;
            bus.issue_payload  <= '0;
            bus.issue_dest_tag <= '0;
            bus.issue_index    <= '0;
        end else begin
            valid              <= valid_nxt;
            count              <= popcnt(valid_nxt);
            bus.dispatch_ready <= ~&valid_nxt;
            if (flush) begin
                bus.issue_valid <= 1'b0;
            end else if (load) begin
                bus.issue_valid <= any_req;
                if (any_req) begin
                    bus.issue_payload  <= payload[grant_idx];
                    bus.issue_dest_tag <= dest[grant_idx];
                    bus.issue_index    <= grant_idx;
                end
            end
        end
    end
endmodule
